// File: rtl/comp_search_ctrl_pkg.sv
// Shared constants and state encoding for the comparator-driven binary search controller.
package comp_search_ctrl_pkg;

   localparam int DEF_WIDTH  = 18;
   localparam int DEF_STEP_W = 5;
   localparam int MAX_PROBES = DEF_WIDTH + 1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_PROBE  = 2'd1,
      ST_FINISH = 2'd2
   } state_e;

   // Comparator flags packed as {above, equal, below}
   localparam logic [2:0] FLAG_ABOVE = 3'b100;
   localparam logic [2:0] FLAG_EQUAL = 3'b010;
   localparam logic [2:0] FLAG_BELOW = 3'b001;

endpackage

// File: rtl/comp_search_ctrl_if.sv
// Request/response and comparator signals between a host, the comparator and the search controller.
interface comp_search_ctrl_if
   import comp_search_ctrl_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int STEP_W = DEF_STEP_W
);

   logic              start;
   logic [WIDTH-1:0]  lo_bound;
   logic [WIDTH-1:0]  hi_bound;
   logic [WIDTH-1:0]  guess;
   logic              above;
   logic              equal;
   logic              below;
   logic              busy;
   logic              done;
   logic              found;
   logic              err;
   logic [WIDTH-1:0]  result;
   logic [STEP_W-1:0] steps;

   modport slave (
      input  start, lo_bound, hi_bound, above, equal, below,
      output guess, busy, done, found, err, result, steps
   );

   modport master (
      output start, lo_bound, hi_bound, above, equal, below,
      input  guess, busy, done, found, err, result, steps
   );

endinterface

// File: rtl/comp_search_mid.sv
// Overflow-free midpoint lo + ((hi - lo) >> 1); caller guarantees lo <= hi when the result is used.
module comp_search_mid
   import comp_search_ctrl_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic [WIDTH-1:0] lo_i,
   input  logic [WIDTH-1:0] hi_i,
   output logic [WIDTH-1:0] mid_o
);

   logic [WIDTH:0] lo_x;
   logic [WIDTH:0] hi_x;
   logic [WIDTH:0] half;
   logic [WIDTH:0] sum;
   logic           unused_sum_msb;

   assign lo_x  = {1'b0, lo_i};
   assign hi_x  = {1'b0, hi_i};
   assign half  = (hi_x - lo_x) >> 1;
   assign sum   = lo_x + half;
   assign mid_o = sum[WIDTH-1:0];

   // Top bit is always clear for lo <= hi
   assign unused_sum_msb = sum[WIDTH];

endmodule

// File: rtl/comp_search_ctrl.sv
// Binary-search driver for a three-way comparator: owns operand B and converges on A inside [lo, hi].
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | waiting for start; outputs hold the last search's results
// ST_PROBE  | guess on B, comparator flags sampled at the end of the cycle
// ST_FINISH | one-cycle done pulse, then back to idle
module comp_search_ctrl
   import comp_search_ctrl_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int STEP_W = DEF_STEP_W
) (
   input  logic               clk,
   input  logic               rst,
   comp_search_ctrl_if.slave  bus
);

   localparam logic [WIDTH-1:0]  ONE_W = WIDTH'(1);
   localparam logic [STEP_W-1:0] ONE_S = STEP_W'(1);

   state_e            state_q, state_d;
   logic [WIDTH-1:0]  lo_q, lo_d;
   logic [WIDTH-1:0]  hi_q, hi_d;
   logic [WIDTH-1:0]  guess_q, guess_d;
   logic [WIDTH-1:0]  result_q, result_d;
   logic [STEP_W-1:0] steps_q, steps_d;
   logic              found_q, found_d;
   logic              err_q, err_d;

   logic [WIDTH-1:0]  mid_lo, mid_hi, mid;
   logic [WIDTH-1:0]  guess_p1, guess_m1;
   logic              guess_max, guess_min;
   logic [2:0]        flags;

   assign flags     = {bus.above, bus.equal, bus.below};
   assign guess_p1  = guess_q + ONE_W;
   assign guess_m1  = guess_q - ONE_W;
   assign guess_max = &guess_q;
   assign guess_min = ~|guess_q;

   // One midpoint unit serves both the start load and the narrowed window
   always_comb begin
      mid_lo = bus.lo_bound;
      mid_hi = bus.hi_bound;
      if (state_q == ST_PROBE) begin
         if (bus.below) begin
            mid_lo = lo_q;
            mid_hi = guess_m1;
         end else begin
            mid_lo = guess_p1;
            mid_hi = hi_q;
         end
      end
   end

   comp_search_mid #(.WIDTH(WIDTH)) u_mid (
      .lo_i  (mid_lo),
      .hi_i  (mid_hi),
      .mid_o (mid)
   );

   always_comb begin
      state_d  = state_q;
      lo_d     = lo_q;
      hi_d     = hi_q;
      guess_d  = guess_q;
      result_d = result_q;
      steps_d  = steps_q;
      found_d  = found_q;
      err_d    = err_q;

      unique case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               lo_d     = bus.lo_bound;
               hi_d     = bus.hi_bound;
               found_d  = 1'b0;
               err_d    = 1'b0;
               result_d = '0;
               steps_d  = '0;
               if (bus.lo_bound > bus.hi_bound) begin
                  state_d = ST_FINISH;
               end else begin
                  guess_d = mid;
                  state_d = ST_PROBE;
               end
            end
         end

         ST_PROBE: begin
            steps_d = steps_q + ONE_S;
            case (flags)
               FLAG_EQUAL: begin
                  found_d  = 1'b1;
                  result_d = guess_q;
                  state_d  = ST_FINISH;
               end
               FLAG_ABOVE: begin
                  if (guess_max) begin
                     state_d = ST_FINISH;
                  end else begin
                     lo_d = guess_p1;
                     if (guess_p1 > hi_q) begin
                        state_d = ST_FINISH;
                     end else begin
                        guess_d = mid;
                     end
                  end
               end
               FLAG_BELOW: begin
                  if (guess_min) begin
                     state_d = ST_FINISH;
                  end else begin
                     hi_d = guess_m1;
                     if (lo_q > guess_m1) begin
                        state_d = ST_FINISH;
                     end else begin
                        guess_d = mid;
                     end
                  end
               end
               default: begin
                  err_d   = 1'b1;
                  found_d = 1'b0;
                  state_d = ST_FINISH;
               end
            endcase
         end

         ST_FINISH: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         lo_q     <= '0;
         hi_q     <= '0;
         guess_q  <= '0;
         result_q <= '0;
         steps_q  <= '0;
         found_q  <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         lo_q     <= lo_d;
         hi_q     <= hi_d;
         guess_q  <= guess_d;
         result_q <= result_d;
         steps_q  <= steps_d;
         found_q  <= found_d;
         err_q    <= err_d;
      end
   end

   assign bus.guess  = guess_q;
   assign bus.busy   = (state_q == ST_PROBE);
   assign bus.done   = (state_q == ST_FINISH);
   assign bus.found  = found_q;
   assign bus.err    = err_q;
   assign bus.result = result_q;
   assign bus.steps  = steps_q;

endmodule

// File: tb/tb_comp_search_ctrl.sv
// Bench for comp_search_ctrl: behavioural comparator plus an integer binary-search reference model.
module tb_comp_search_ctrl;
   import comp_search_ctrl_pkg::*;

   localparam int W    = DEF_WIDTH;
   localparam int SW   = DEF_STEP_W;
   localparam int ALL1 = (1 << W) - 1;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   comp_search_ctrl_if #(.WIDTH(W), .STEP_W(SW)) bus ();

   comp_search_ctrl #(.WIDTH(W), .STEP_W(SW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [W-1:0] a_val;
   logic         force_en;
   logic [2:0]   force_flags;

   assign bus.above = force_en ? force_flags[2] : (a_val >  bus.guess);
   assign bus.equal = force_en ? force_flags[1] : (a_val == bus.guess);
   assign bus.below = force_en ? force_flags[0] : (a_val <  bus.guess);

   int checks   = 0;
   int failures = 0;

   int exp_g[$];
   int exp_found;
   int exp_steps;

   int          obs_g[$];
   int          obs_cycles;
   logic        obs_timeout;
   logic        obs_done_after;
   logic        obs_found;
   logic        obs_err;
   logic [W-1:0]  obs_result;
   logic [W-1:0]  obs_guess;
   logic [SW-1:0] obs_steps;

   typedef struct {
      int lo;
      int hi;
      int a;
      int steps;
   } vec_t;

   // Reference: textbook binary search on integers, no width tricks needed
   task automatic model_search(input int lo, input int hi, input int a);
      int l;
      int h;
      int g;
      exp_g.delete();
      exp_found = 0;
      l = lo;
      h = hi;
      while (l <= h) begin
         g = l + (h - l) / 2;
         exp_g.push_back(g);
         if (g == a) begin
            exp_found = 1;
            break;
         end else if (a > g) begin
            l = g + 1;
         end else begin
            h = g - 1;
         end
      end
      exp_steps = exp_g.size();
   endtask

   task automatic do_search(input int lo, input int hi, input int a);
      a_val = a[W-1:0];
      @(negedge clk);
      bus.start    = 1'b1;
      bus.lo_bound = lo[W-1:0];
      bus.hi_bound = hi[W-1:0];
      @(negedge clk);
      bus.start   = 1'b0;
      obs_g.delete();
      obs_timeout = 1'b1;
      obs_cycles  = -1;
      for (int c = 0; c < 64; c++) begin
         if (bus.done) begin
            obs_timeout = 1'b0;
            obs_cycles  = c;
            obs_found   = bus.found;
            obs_err     = bus.err;
            obs_result  = bus.result;
            obs_guess   = bus.guess;
            obs_steps   = bus.steps;
            break;
         end
         if (bus.busy) obs_g.push_back(int'(bus.guess));
         @(negedge clk);
      end
      @(negedge clk);
      obs_done_after = bus.done;
   endtask

   task automatic test_reset();
      rst          = 1'b1;
      bus.start    = 1'b1;
      bus.lo_bound = W'(0);
      bus.hi_bound = W'(7);
      a_val        = W'(5);
      repeat (3) @(negedge clk);
      rst       = 1'b0;
      bus.start = 1'b0;
      checks++;
      if ({bus.busy, bus.done, bus.found, bus.err} !== 4'b0000) begin
         failures++;
         $display("FAIL reset_flags: busy/done/found/err got %b want 0000",
                  {bus.busy, bus.done, bus.found, bus.err});
      end
      checks++;
      if (bus.guess !== W'(0) || bus.result !== W'(0) || bus.steps !== SW'(0)) begin
         failures++;
         $display("FAIL reset_values: guess=%0d result=%0d steps=%0d want 0 0 0",
                  bus.guess, bus.result, bus.steps);
      end
      @(negedge clk);
      checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
         failures++;
         $display("FAIL reset_start_ignored: busy=%b done=%b want 0 0", bus.busy, bus.done);
      end
   endtask

   task automatic test_search_vectors();
      vec_t tbl[$];
      vec_t v;
      int   span;
      int   mode;
      logic seq_ok;
      tbl.push_back('{lo: 0,         hi: 7,         a: 5,         steps: 2});
      tbl.push_back('{lo: 10,        hi: 20,        a: 25,        steps: 4});
      tbl.push_back('{lo: 0,         hi: ALL1,      a: ALL1,      steps: -1});
      tbl.push_back('{lo: ALL1 - 1,  hi: ALL1 - 1,  a: ALL1,      steps: 1});
      tbl.push_back('{lo: 0,         hi: 0,         a: 0,         steps: 1});
      tbl.push_back('{lo: 5,         hi: 4,         a: 4,         steps: 0});
      tbl.push_back('{lo: 0,         hi: ALL1,      a: 0,         steps: -1});
      tbl.push_back('{lo: 100,       hi: 200,       a: 3,         steps: -1});
      for (int n = 0; n < 30; n++) begin
         mode  = int'($urandom_range(0, 3));
         v.lo  = int'($urandom_range(0, ALL1));
         span  = (mode == 0) ? int'($urandom_range(0, 20)) : int'($urandom_range(0, ALL1));
         v.hi  = (v.lo + span > ALL1) ? ALL1 : v.lo + span;
         if (mode == 3) v.a = int'($urandom_range(0, ALL1));
         else           v.a = v.lo + int'($urandom_range(0, v.hi - v.lo));
         if (mode == 3 && $urandom_range(0, 3) == 0 && v.hi > v.lo) begin
            span = v.lo;
            v.lo = v.hi;
            v.hi = span;
         end
         v.steps = -1;
         tbl.push_back(v);
      end

      foreach (tbl[i]) begin
         v = tbl[i];
         model_search(v.lo, v.hi, v.a);
         do_search(v.lo, v.hi, v.a);
         checks++;
         if (obs_timeout) begin
            failures++;
            $display("FAIL vec%0d_timeout: no done within 64 cycles want done", i);
            continue;
         end
         checks++;
         if (obs_found !== exp_found[0]) begin
            failures++;
            $display("FAIL vec%0d_found: lo=%0d hi=%0d a=%0d got %b want %0d",
                     i, v.lo, v.hi, v.a, obs_found, exp_found);
         end
         checks++;
         if (obs_err !== 1'b0) begin
            failures++;
            $display("FAIL vec%0d_err: got %b want 0", i, obs_err);
         end
         checks++;
         if (int'(obs_result) !== (exp_found ? v.a : 0)) begin
            failures++;
            $display("FAIL vec%0d_result: got %0d want %0d", i, obs_result, exp_found ? v.a : 0);
         end
         checks++;
         if (int'(obs_steps) !== exp_steps) begin
            failures++;
            $display("FAIL vec%0d_steps: lo=%0d hi=%0d a=%0d got %0d want %0d",
                     i, v.lo, v.hi, v.a, obs_steps, exp_steps);
         end
         if (v.steps >= 0) begin
            checks++;
            if (int'(obs_steps) !== v.steps) begin
               failures++;
               $display("FAIL vec%0d_steps_table: got %0d want %0d", i, obs_steps, v.steps);
            end
         end
         checks++;
         if (int'(obs_steps) > MAX_PROBES) begin
            failures++;
            $display("FAIL vec%0d_steps_bound: got %0d want <= %0d", i, obs_steps, MAX_PROBES);
         end
         seq_ok = (obs_g.size() == exp_g.size());
         if (seq_ok) begin
            foreach (exp_g[k]) if (obs_g[k] != exp_g[k]) seq_ok = 1'b0;
         end
         checks++;
         if (!seq_ok) begin
            failures++;
            $display("FAIL vec%0d_sequence: got %0d probes want %0d (first got %0d want %0d)",
                     i, obs_g.size(), exp_g.size(),
                     (obs_g.size() > 0) ? obs_g[0] : -1, (exp_g.size() > 0) ? exp_g[0] : -1);
         end
         if (exp_steps > 0) begin
            checks++;
            if (int'(obs_guess) !== exp_g[exp_steps - 1]) begin
               failures++;
               $display("FAIL vec%0d_guess_hold: got %0d want %0d", i, obs_guess, exp_g[exp_steps - 1]);
            end
         end
         checks++;
         if (obs_cycles !== exp_steps) begin
            failures++;
            $display("FAIL vec%0d_latency: done after %0d cycles want %0d", i, obs_cycles, exp_steps);
         end
         checks++;
         if (obs_done_after !== 1'b0) begin
            failures++;
            $display("FAIL vec%0d_done_pulse: done still %b next cycle want 0", i, obs_done_after);
         end
      end
   endtask

   task automatic test_forced_flags();
      logic seen;
      // No flags at all on the first probe
      force_en    = 1'b1;
      force_flags = 3'b000;
      do_search(0, 7, 5);
      checks++;
      if (obs_timeout || obs_err !== 1'b1 || obs_found !== 1'b0 || obs_steps !== SW'(1)
          || obs_result !== W'(0) || obs_cycles !== 1) begin
         failures++;
         $display("FAIL flags000: to=%b err=%b found=%b steps=%0d result=%0d cyc=%0d want 0 1 0 1 0 1",
                  obs_timeout, obs_err, obs_found, obs_steps, obs_result, obs_cycles);
      end

      // Normal first probe, then above+equal together on the second
      force_en = 1'b0;
      a_val    = W'(5);
      @(negedge clk);
      bus.start    = 1'b1;
      bus.lo_bound = W'(0);
      bus.hi_bound = W'(7);
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      force_en    = 1'b1;
      force_flags = 3'b110;
      seen = 1'b0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (bus.done) begin
            seen = 1'b1;
            break;
         end
      end
      checks++;
      if (!seen || bus.err !== 1'b1 || bus.found !== 1'b0 || bus.steps !== SW'(2)
          || bus.guess !== W'(5)) begin
         failures++;
         $display("FAIL flags110: done=%b err=%b found=%b steps=%0d guess=%0d want 1 1 0 2 5",
                  seen, bus.err, bus.found, bus.steps, bus.guess);
      end

      // Above reported at the all-ones guess must not wrap
      force_flags = 3'b100;
      do_search(ALL1, ALL1, 0);
      checks++;
      if (obs_timeout || obs_found !== 1'b0 || obs_err !== 1'b0 || obs_steps !== SW'(1)
          || int'(obs_guess) !== ALL1 || obs_cycles !== 1) begin
         failures++;
         $display("FAIL above_at_max: to=%b found=%b err=%b steps=%0d guess=%0d cyc=%0d want 0 0 0 1 %0d 1",
                  obs_timeout, obs_found, obs_err, obs_steps, obs_guess, obs_cycles, ALL1);
      end

      // Below reported at guess 0 must not underflow
      force_flags = 3'b001;
      do_search(0, 0, 0);
      checks++;
      if (obs_timeout || obs_found !== 1'b0 || obs_err !== 1'b0 || obs_steps !== SW'(1)
          || obs_guess !== W'(0) || obs_cycles !== 1) begin
         failures++;
         $display("FAIL below_at_zero: to=%b found=%b err=%b steps=%0d guess=%0d cyc=%0d want 0 0 0 1 0 1",
                  obs_timeout, obs_found, obs_err, obs_steps, obs_guess, obs_cycles);
      end
      force_en = 1'b0;
   endtask

   task automatic test_dropped_start();
      logic seen;
      a_val = W'(5);
      @(negedge clk);
      bus.start    = 1'b1;
      bus.lo_bound = W'(0);
      bus.hi_bound = W'(7);
      @(negedge clk);
      bus.lo_bound = W'(100);
      bus.hi_bound = W'(200);
      @(negedge clk);
      bus.start = 1'b0;
      seen = bus.done;
      for (int c = 0; c < 8 && !seen; c++) begin
         @(negedge clk);
         seen = bus.done;
      end
      checks++;
      if (!seen || bus.found !== 1'b1 || bus.result !== W'(5) || bus.steps !== SW'(2)) begin
         failures++;
         $display("FAIL start_in_probe: done=%b found=%b result=%0d steps=%0d want 1 1 5 2",
                  seen, bus.found, bus.result, bus.steps);
      end
      bus.start    = 1'b1;
      bus.lo_bound = W'(0);
      bus.hi_bound = W'(7);
      @(negedge clk);
      bus.start = 1'b0;
      checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.found !== 1'b1) begin
         failures++;
         $display("FAIL start_in_finish: busy=%b done=%b found=%b want 0 0 1",
                  bus.busy, bus.done, bus.found);
      end
   endtask

   task automatic test_reset_midsearch();
      logic saw_done;
      a_val = W'(0);
      @(negedge clk);
      bus.start    = 1'b1;
      bus.lo_bound = W'(0);
      bus.hi_bound = W'(ALL1);
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if ({bus.busy, bus.done, bus.found, bus.err} !== 4'b0000 || bus.guess !== W'(0)
          || bus.result !== W'(0) || bus.steps !== SW'(0)) begin
         failures++;
         $display("FAIL reset_mid: busy=%b done=%b found=%b err=%b guess=%0d result=%0d steps=%0d want all 0",
                  bus.busy, bus.done, bus.found, bus.err, bus.guess, bus.result, bus.steps);
      end
      saw_done = 1'b0;
      repeat (4) begin
         @(negedge clk);
         if (bus.done || bus.busy) saw_done = 1'b1;
      end
      checks++;
      if (saw_done) begin
         failures++;
         $display("FAIL reset_mid_quiet: done/busy seen %b after reset want 0", saw_done);
      end
      do_search(0, 7, 5);
      checks++;
      if (obs_timeout || obs_found !== 1'b1 || obs_result !== W'(5) || obs_steps !== SW'(2)
          || obs_err !== 1'b0) begin
         failures++;
         $display("FAIL reset_recover: to=%b found=%b result=%0d steps=%0d err=%b want 0 1 5 2 0",
                  obs_timeout, obs_found, obs_result, obs_steps, obs_err);
      end
   endtask

   initial begin
      force_en     = 1'b0;
      force_flags  = 3'b000;
      a_val        = '0;
      bus.start    = 1'b0;
      bus.lo_bound = '0;
      bus.hi_bound = '0;
      rst          = 1'b1;
      test_reset();
      test_search_vectors();
      test_forced_flags();
      test_dropped_start();
      test_reset_midsearch();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
